// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, line levels and the baud divisor clamp.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_e;

    localparam logic [15:0] MIN_BAUD_DIV    = 16'd4;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < MIN_BAUD_DIV) ? MIN_BAUD_DIV : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// Flush beats push/pop; a push into a full FIFO with no pop drops the byte and flags overrun.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int FIFO_AW   = 3,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic                 valid,
    output logic                 overrun,
    output logic [FIFO_AW:0]     level
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

    logic [FIFO_AW:0]     wr_ptr_r;
    logic [FIFO_AW:0]     rd_ptr_r;
    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic                 overrun_r;
    logic [FIFO_AW:0]     level_s;
    logic                 full_s;
    logic                 do_pop_s;
    logic                 do_push_s;
    logic                 drop_s;

    // Occupancy and the accept/drop decision for this cycle.
    always_comb begin
        level_s   = wr_ptr_r - rd_ptr_r;
        full_s    = (level_s == DEPTH_L);
        do_pop_s  = pop && (level_s != {(FIFO_AW + 1){1'b0}});
        do_push_s = push && (!full_s || do_pop_s);
        drop_s    = push && full_s && !do_pop_s;
    end

    // Pointer and overrun flag update; flush wins over any push or pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            overrun_r <= drop_s;
        end
    end

    // Storage; cleared on reset so the head reads zero until the first byte lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r[FIFO_AW-1:0]] <= push_data;
        end
    end

    assign head    = mem_r[rd_ptr_r[FIFO_AW-1:0]];
    assign valid   = (level_s != {(FIFO_AW + 1){1'b0}});
    assign overrun = overrun_r;
    assign level   = level_s;

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: synchronizer, mid-bit sampling FSM and FWFT byte FIFO
// drained through a valid/ready port, with framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_AW   = 3,
    parameter int DATA_BITS = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [15:0]          baud_div,
    input  logic                 rx_i,
    input  logic                 rx_flush,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [FIFO_AW:0]     fifo_level
);

    localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic                 sync1_r;
    logic                 rx_sync_r;
    rx_state_e            state_r, state_n;
    logic [15:0]          bit_cnt_r, bit_cnt_n;
    logic [15:0]          div_r, div_n;
    logic [IDX_W-1:0]     bit_idx_r, bit_idx_n;
    logic [DATA_BITS-1:0] shreg_r, shreg_n;
    logic                 push_r, push_s;
    logic                 frame_err_r, frame_err_s;
    logic                 busy_r;
    logic [15:0]          div_in_s;

    assign div_in_s = clamp_div(baud_div);

    // Next-state and datapath decisions for the receive FSM.
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        div_n       = div_r;
        bit_idx_n   = bit_idx_r;
        shreg_n     = shreg_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_sync_r != UART_IDLE_LEVEL) begin
                    div_n     = div_in_s;
                    bit_cnt_n = {1'b0, div_in_s[15:1]};
                    state_n   = START;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (bit_cnt_r != 16'd0) begin
                    bit_cnt_n = bit_cnt_r - 16'd1;
                end else if (rx_sync_r == 1'b0) begin
                    bit_cnt_n = div_r - 16'd1;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (bit_cnt_r != 16'd0) begin
                    bit_cnt_n = bit_cnt_r - 16'd1;
                end else begin
                    shreg_n   = {rx_sync_r, shreg_r[DATA_BITS-1:1]};
                    bit_cnt_n = div_r - 16'd1;
                    if (bit_idx_r == LAST_IDX) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx_r + IDX_ONE;
                    end
                end
            end
            STOP: begin
                if (bit_cnt_r != 16'd0) begin
                    bit_cnt_n = bit_cnt_r - 16'd1;
                end else if (rx_sync_r == 1'b1) begin
                    push_s  = 1'b1;
                    state_n = IDLE;
                end else begin
                    frame_err_s = 1'b1;
                    state_n     = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A held-low break must return high before a new frame can start.
                if (rx_sync_r == 1'b1) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT_HI;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Synchronizer, FSM state and registered status outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_r     <= UART_IDLE_LEVEL;
            rx_sync_r   <= UART_IDLE_LEVEL;
            state_r     <= IDLE;
            bit_cnt_r   <= 16'd0;
            div_r       <= MIN_BAUD_DIV;
            bit_idx_r   <= '0;
            shreg_r     <= '0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            sync1_r     <= rx_i;
            rx_sync_r   <= sync1_r;
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            div_r       <= div_n;
            bit_idx_r   <= bit_idx_n;
            shreg_r     <= shreg_n;
            push_r      <= push_s;
            frame_err_r <= frame_err_s;
            busy_r      <= (state_n != IDLE);
        end
    end

    // shreg_r holds the completed byte through the push cycle: IDLE and START never shift it.
    uart_rx_fifo #(
        .FIFO_AW   (FIFO_AW),
        .DATA_BITS (DATA_BITS)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (rx_flush),
        .push      (push_r),
        .push_data (shreg_r),
        .pop       (rx_ready),
        .head      (rx_data),
        .valid     (rx_valid),
        .overrun   (overrun),
        .level     (fifo_level)
    );

    assign rx_busy   = busy_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: serial frames are generated from the 8N1 rules,
// expected bytes are queued at send time and a monitor checks every accepted byte.
`timescale 1ns/1ps
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        rx_i;
    logic        rx_flush;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;
    logic [3:0]  fifo_level;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         valid_cycles = 0;
    bit         prev_fe  = 1'b0;
    bit         prev_ov  = 1'b0;
    logic [7:0] exp_q [$];

    uart_rx_core #(.FIFO_AW(3), .DATA_BITS(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .baud_div   (baud_div),
        .rx_i       (rx_i),
        .rx_flush   (rx_flush),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Hold the line at v for n clocks; inputs always change 1ns after a rising edge.
    task automatic drive(input logic v, input int n);
        rx_i = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame; the bit period follows the documented clamp of the divisor.
    task automatic send_frame(input logic [7:0] b, input int bd, input logic stop, input bit scramble);
        int p;
        p = (bd < 4) ? 4 : bd;
        baud_div = 16'(bd);
        drive(1'b0, p);
        if (scramble) baud_div = 16'($urandom);
        for (int i = 0; i < 8; i++) drive(b[i], p);
        drive(stop, p);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_busy"}, rx_busy, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_data"}, rx_data, 0);
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on every accepted byte, counts pulses.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_q.pop_front());
                end
            end
            if (frame_err) begin
                fe_cnt++;
                check("frame_err_width", prev_fe, 0);
            end
            if (overrun) begin
                ov_cnt++;
                check("overrun_width", prev_ov, 0);
            end
            prev_fe = frame_err;
            prev_ov = overrun;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] t1_bytes [4];
        int v0, fe0, ov0, fe_rnd;
        bit rnd_done;
        t1_bytes[0] = 8'h0F; t1_bytes[1] = 8'h3D; t1_bytes[2] = 8'h4F; t1_bytes[3] = 8'h29;
        rst = 1'b1; baud_div = 16'd16; rx_i = 1'b1; rx_flush = 1'b0; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        drive(1'b1, 4);

        // Basic reception with an always-ready consumer.
        rx_ready = 1'b1;
        v0 = valid_cycles;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(t1_bytes[i]);
            send_frame(t1_bytes[i], 16, 1'b1, 1'b0);
        end
        drive(1'b1, 32);
        wait_drain("t1_drain", 200);
        check("t1_valid_cycles", valid_cycles - v0, 4);
        check("t1_frame_err", fe_cnt, 0);
        check("t1_overrun", ov_cnt, 0);

        // Fill past capacity: ninth byte is dropped with one overrun pulse.
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send_frame(8'(i), 16, 1'b1, 1'b0);
        end
        drive(1'b1, 20);
        check("t2_level_full", fifo_level, 8);
        check("t2_overrun_once", ov_cnt - ov0, 1);
        rx_ready = 1'b1;
        wait_drain("t2_drain", 200);
        check("t2_level_empty", fifo_level, 0);

        // Short low glitch aborts in START with no flags.
        fe0 = fe_cnt; ov0 = ov_cnt;
        drive(1'b0, 5);
        check("t3_busy_started", rx_busy, 1);
        drive(1'b1, 20);
        check("t3_busy_back", rx_busy, 0);
        check("t3_level", fifo_level, 0);
        check("t3_no_fe", fe_cnt - fe0, 0);
        check("t3_no_ov", ov_cnt - ov0, 0);

        // Bad stop bit then a held-low break; only the following 0xA5 arrives.
        fe0 = fe_cnt;
        send_frame(8'h55, 16, 1'b0, 1'b0);
        drive(1'b0, 20);
        check("t4_wait_hi_busy", rx_busy, 1);
        drive(1'b0, 20);
        drive(1'b1, 32);
        check("t4_idle_after_break", rx_busy, 0);
        check("t4_frame_err_once", fe_cnt - fe0, 1);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 16, 1'b1, 1'b0);
        drive(1'b1, 16);
        wait_drain("t4_drain", 200);

        // Full FIFO with a pop landing exactly on the push cycle of a ninth byte.
        rx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            send_frame(8'hA0 + 8'(i), 16, 1'b1, 1'b0);
        end
        drive(1'b1, 16);
        check("t5_level_full", fifo_level, 8);
        ov0 = ov_cnt;
        exp_q.push_back(8'hC3);
        fork
            send_frame(8'hC3, 16, 1'b1, 1'b0);
            begin
                int k;
                k = 0;
                while (rx_busy !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
                while (rx_busy !== 1'b0 && k < 1000) begin @(negedge clk); k++; end
                check("t5_push_cycle_found", (k < 1000) ? 1 : 0, 1);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        drive(1'b1, 4);
        check("t5_level_still_full", fifo_level, 8);
        check("t5_no_overrun", ov_cnt - ov0, 0);
        rx_ready = 1'b1;
        wait_drain("t5_drain", 200);

        // Reset mid-frame during bit 4 of 0x3C, with a stale byte sitting in the FIFO.
        rx_ready = 1'b0;
        send_frame(8'h77, 16, 1'b1, 1'b0);
        drive(1'b1, 16);
        check("t6_setup_level", fifo_level, 1);
        drive(1'b0, 16);
        drive(1'b0, 16); drive(1'b0, 16); drive(1'b1, 16); drive(1'b1, 16);
        drive(1'b1, 8);
        check("t6_busy_before_rst", rx_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_vals("t6_mid_rst");
        drive(1'b1, 48);
        rx_ready = 1'b1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 16, 1'b1, 1'b0);
        drive(1'b1, 16);
        wait_drain("t6_drain", 200);

        // Flush discards buffered bytes.
        rx_ready = 1'b0;
        send_frame(8'h11, 8, 1'b1, 1'b0);
        send_frame(8'h22, 8, 1'b1, 1'b0);
        drive(1'b1, 8);
        check("t7_level_before_flush", fifo_level, 2);
        rx_flush = 1'b1;
        @(posedge clk);
        #1 rx_flush = 1'b0;
        check("t7_level_after_flush", fifo_level, 0);
        check("t7_valid_after_flush", rx_valid, 0);

        // Random bytes, divisors (incl. clamped ones), mid-frame divisor changes,
        // occasional bad stop bits and a randomly throttled consumer.
        fe0 = fe_cnt; fe_rnd = 0; rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    int bd;
                    bit bad;
                    logic [7:0] b;
                    bd  = int'($urandom_range(1, 16));
                    bad = ($urandom_range(0, 7) == 0);
                    b   = 8'($urandom);
                    if (bad) fe_rnd++;
                    else exp_q.push_back(b);
                    send_frame(b, bd, !bad, 1'b1);
                    drive(1'b1, int'($urandom_range(1, 20)) + (bad ? 16 : 0));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        rx_ready = 1'b1;
        wait_drain("rnd_drain", 400);
        check("rnd_frame_errs", fe_cnt - fe0, fe_rnd);
        check("total_overruns", ov_cnt, 1);
        check("final_level", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
